// File: rtl/tlb_search_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tlb_search_arbiter_pkg
//   Shared constants and types for the TLB search arbiter slice:
//   - default TLB field widths (virtual page-pair number, physical frame)
//   - the kseg0/kseg1 segment encoding that bypasses the TLB
//   - flag bit positions inside a response slot
//   - response slot state encoding
// ---------------------------------------------------------------------------
package tlb_search_arbiter_pkg;

  localparam int VPN2_WD          = 19;
  localparam int PFN_WD           = 20;
  localparam int STARVE_LIMIT_DEF = 3;

  // vaddr[31:30] == 2'b10 selects kseg0 (0x8000_0000) or kseg1 (0xA000_0000);
  // both map straight onto the low 512 MB of physical space.
  localparam logic [1:0] KSEG01_HI = 2'b10;

  // Flag positions inside a slot's flag vector. The inst slot carries only
  // the first two; the data slot carries all three.
  localparam int FLAG_REFILL   = 0;
  localparam int FLAG_INVALID  = 1;
  localparam int FLAG_MODIFIED = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic is_unmapped(input logic [31:0] vaddr);
    return vaddr[31:30] == KSEG01_HI;
  endfunction

endpackage

// File: rtl/tlb_search_arbiter_resp_slot.sv
// ---------------------------------------------------------------------------
// tlb_search_arbiter_resp_slot
//   One-entry response holding register for a single requester.
//   Captures a translated paddr plus FLAG_W exception flags on load and holds
//   them until the consumer drains the slot. A clear empties the slot
//   regardless of load/drain (used for pipeline flush).
// Ports
//   clk, resetn        clock, async active-low reset
//   load               store load_paddr/load_flags, slot becomes FULL
//   drain              consumer takes the response this cycle
//   clear              force EMPTY (wins over load and drain)
//   load_paddr/flags   payload captured on load
//   valid              slot FULL
//   paddr/flags        held payload
// ---------------------------------------------------------------------------
module tlb_search_arbiter_resp_slot
  import tlb_search_arbiter_pkg::*;
#(
  parameter int FLAG_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [31:0]       load_paddr,
  input  logic [FLAG_W-1:0] load_flags,
  output logic              valid,
  output logic [31:0]       paddr,
  output logic [FLAG_W-1:0] flags
);

  slot_state_e state_q, state_d;

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= SLOT_EMPTY;
    else         state_q <= state_d;
  end

  // NOTE: the default assignment first means every path drives state_d, so
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (clear)      state_d = SLOT_EMPTY;
    else if (load)  state_d = SLOT_FULL;   // load with drain = back-to-back reload
    else if (drain) state_d = SLOT_EMPTY;
  end

  // NOTE: the payload is reset as well because paddr and flags are visible
  // outputs that must read 0 after reset, not just qualified by valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      paddr <= '0;
      flags <= '0;
    end else if (load && !clear) begin
      paddr <= load_paddr;
      flags <= load_flags;
    end
  end

  assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/tlb_search_arbiter.sv
// ---------------------------------------------------------------------------
// tlb_search_arbiter
//   Shares the single combinational TLB search port between instruction fetch
//   and data access. Each accepted request drives the search port in its
//   grant cycle; the translated paddr and exception flags land in that
//   requester's response slot on the next edge and stay there until consumed.
//   kseg0/kseg1 addresses bypass the TLB with the same one-cycle latency.
//   Data wins arbitration by default; a waiting inst request wins once it has
//   lost STARVE_LIMIT consecutive cycles. flush kills inst traffic only.
// Ports
//   clk, resetn                       clock, async active-low reset
//   flush                             drop inst slot, block inst grant
//   inst_req/inst_vaddr/inst_ready    inst request handshake (ready comb.)
//   inst_resp_*/inst_paddr/inst_*     inst response slot
//   data_req/data_vaddr/data_wr/...   data request handshake (ready comb.)
//   data_resp_*/data_paddr/data_*     data response slot
//   s_vpn2/s_odd_page                 TLB search key (0 when idle)
//   s_found/s_pfn/s_v/s_d             TLB search result
// ---------------------------------------------------------------------------
module tlb_search_arbiter
  import tlb_search_arbiter_pkg::*;
#(
  parameter int VPN2_W       = VPN2_WD,
  parameter int PFN_W        = PFN_WD,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [31:0]       inst_vaddr,
  output logic              inst_ready,
  output logic              inst_resp_valid,
  input  logic              inst_resp_ready,
  output logic [31:0]       inst_paddr,
  output logic              inst_refill,
  output logic              inst_invalid,
  input  logic              data_req,
  input  logic [31:0]       data_vaddr,
  input  logic              data_wr,
  output logic              data_ready,
  output logic              data_resp_valid,
  input  logic              data_resp_ready,
  output logic [31:0]       data_paddr,
  output logic              data_refill,
  output logic              data_invalid,
  output logic              data_modified,
  output logic [VPN2_W-1:0] s_vpn2,
  output logic              s_odd_page,
  input  logic              s_found,
  input  logic [PFN_W-1:0]  s_pfn,
  input  logic              s_v,
  input  logic              s_d
);

  localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             inst_elig, data_elig;
  logic             grant_inst, grant_data, any_grant;
  logic [31:0]      sel_vaddr;
  logic             mapped;
  logic [31:0]      xl_paddr;
  logic             xl_refill, xl_invalid, xl_modified;
  logic [1:0]       inst_flags_d, inst_flags_q;
  logic [2:0]       data_flags_d, data_flags_q;

  // ---- arbitration --------------------------------------------------------
  // A requester can be accepted when its slot is free now or is being drained
  // this same cycle. Flush removes inst eligibility outright.
  assign inst_elig = inst_req && !flush && (!inst_resp_valid || inst_resp_ready);
  assign data_elig = data_req && (!data_resp_valid || data_resp_ready);

  assign grant_inst = inst_elig && (!data_elig || starve_cnt == CNT_LIMIT);
  assign grant_data = data_elig && !grant_inst;
  assign any_grant  = grant_inst || grant_data;

  assign inst_ready = grant_inst;
  assign data_ready = grant_data;

  // Counts consecutive cycles inst was eligible but lost; saturates at the
  // limit so the next contested cycle goes to inst.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (flush || !inst_req || grant_inst) begin
      starve_cnt <= '0;
    end else if (inst_elig && starve_cnt != CNT_LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---- search port and translation ----------------------------------------
  assign sel_vaddr  = grant_inst ? inst_vaddr : data_vaddr;
  assign s_vpn2     = any_grant ? VPN2_W'(sel_vaddr[31:13]) : '0;
  assign s_odd_page = any_grant && sel_vaddr[12];

  assign mapped = !is_unmapped(sel_vaddr);

  // Flags come out mutually exclusive: invalid and modified both require a
  // hit, and modified additionally requires V=1.
  assign xl_paddr    = mapped ? 32'({s_pfn, sel_vaddr[11:0]}) : {3'b000, sel_vaddr[28:0]};
  assign xl_refill   = mapped && !s_found;
  assign xl_invalid  = mapped && s_found && !s_v;
  assign xl_modified = mapped && data_wr && s_found && s_v && !s_d;

  always_comb begin
    inst_flags_d = '0;
    data_flags_d = '0;
    inst_flags_d[FLAG_REFILL]   = xl_refill;
    inst_flags_d[FLAG_INVALID]  = xl_invalid;
    data_flags_d[FLAG_REFILL]   = xl_refill;
    data_flags_d[FLAG_INVALID]  = xl_invalid;
    data_flags_d[FLAG_MODIFIED] = xl_modified;
  end

  // ---- response slots -----------------------------------------------------
  tlb_search_arbiter_resp_slot #(.FLAG_W(2)) u_inst_slot (
    .clk        (clk),
    .resetn     (resetn),
    .load       (grant_inst),
    .drain      (inst_resp_ready),
    .clear      (flush),
    .load_paddr (xl_paddr),
    .load_flags (inst_flags_d),
    .valid      (inst_resp_valid),
    .paddr      (inst_paddr),
    .flags      (inst_flags_q)
  );

  tlb_search_arbiter_resp_slot #(.FLAG_W(3)) u_data_slot (
    .clk        (clk),
    .resetn     (resetn),
    .load       (grant_data),
    .drain      (data_resp_ready),
    .clear      (1'b0),
    .load_paddr (xl_paddr),
    .load_flags (data_flags_d),
    .valid      (data_resp_valid),
    .paddr      (data_paddr),
    .flags      (data_flags_q)
  );

  assign inst_refill   = inst_flags_q[FLAG_REFILL];
  assign inst_invalid  = inst_flags_q[FLAG_INVALID];
  assign data_refill   = data_flags_q[FLAG_REFILL];
  assign data_invalid  = data_flags_q[FLAG_INVALID];
  assign data_modified = data_flags_q[FLAG_MODIFIED];

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlb_search_arbiter
//   Directed self-checking bench for tlb_search_arbiter. Inputs change 1 ns
//   after a rising edge; combinational outputs are sampled 1 ns after that,
//   registered outputs 1 ns after the edge that loads them.
// ---------------------------------------------------------------------------
module tb_tlb_search_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_vaddr;
  logic        inst_ready;
  logic        inst_resp_valid;
  logic        inst_resp_ready;
  logic [31:0] inst_paddr;
  logic        inst_refill;
  logic        inst_invalid;
  logic        data_req;
  logic [31:0] data_vaddr;
  logic        data_wr;
  logic        data_ready;
  logic        data_resp_valid;
  logic        data_resp_ready;
  logic [31:0] data_paddr;
  logic        data_refill;
  logic        data_invalid;
  logic        data_modified;
  logic [18:0] s_vpn2;
  logic        s_odd_page;
  logic        s_found;
  logic [19:0] s_pfn;
  logic        s_v;
  logic        s_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_search_arbiter dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .inst_req        (inst_req),
    .inst_vaddr      (inst_vaddr),
    .inst_ready      (inst_ready),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_ready (inst_resp_ready),
    .inst_paddr      (inst_paddr),
    .inst_refill     (inst_refill),
    .inst_invalid    (inst_invalid),
    .data_req        (data_req),
    .data_vaddr      (data_vaddr),
    .data_wr         (data_wr),
    .data_ready      (data_ready),
    .data_resp_valid (data_resp_valid),
    .data_resp_ready (data_resp_ready),
    .data_paddr      (data_paddr),
    .data_refill     (data_refill),
    .data_invalid    (data_invalid),
    .data_modified   (data_modified),
    .s_vpn2          (s_vpn2),
    .s_odd_page      (s_odd_page),
    .s_found         (s_found),
    .s_pfn           (s_pfn),
    .s_v             (s_v),
    .s_d             (s_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush           = 1'b0;
    inst_req        = 1'b0;
    inst_vaddr      = '0;
    inst_resp_ready = 1'b1;
    data_req        = 1'b0;
    data_vaddr      = '0;
    data_wr         = 1'b0;
    data_resp_ready = 1'b1;
    s_found         = 1'b0;
    s_pfn           = '0;
    s_v             = 1'b0;
    s_d             = 1'b0;
  endtask

  task automatic set_tlb(input logic found, input logic [19:0] pfn, input logic v, input logic d);
    s_found = found;
    s_pfn   = pfn;
    s_v     = v;
    s_d     = d;
  endtask

  // One data grant cycle with resp_ready held high; returns 1 ns after the
  // edge that loads the response.
  task automatic do_data(input logic [31:0] va, input logic wr, input logic found,
                         input logic [19:0] pfn, input logic v, input logic d);
    data_req = 1'b1; data_vaddr = va; data_wr = wr; data_resp_ready = 1'b1;
    set_tlb(found, pfn, v, d);
    #1;
    checks++;
    if (data_ready !== 1'b1) begin failures++; $display("FAIL do_data_ready va=%h got=%b exp=1", va, data_ready); end
    tick();
    data_req = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    tick(); tick();
    checks++;
    if (inst_resp_valid !== 1'b0 || data_resp_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got inst=%b data=%b exp=0,0", inst_resp_valid, data_resp_valid);
    end
    checks++;
    if (inst_paddr !== 32'h0 || data_paddr !== 32'h0) begin
      failures++; $display("FAIL reset_paddr got inst=%h data=%h exp=0,0", inst_paddr, data_paddr);
    end
    checks++;
    if ({inst_refill, inst_invalid, data_refill, data_invalid, data_modified} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000",
                           {inst_refill, inst_invalid, data_refill, data_invalid, data_modified});
    end
    checks++;
    if (s_vpn2 !== 19'h0 || s_odd_page !== 1'b0) begin
      failures++; $display("FAIL reset_search_idle got vpn2=%h odd=%b exp=0,0", s_vpn2, s_odd_page);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_inst_only();
    idle();
    inst_resp_ready = 1'b0;
    inst_req = 1'b1; inst_vaddr = 32'h0040_1ABC;
    set_tlb(1'b1, 20'h12345, 1'b1, 1'b0);
    #1;
    checks++;
    if (inst_ready !== 1'b1 || data_ready !== 1'b0) begin
      failures++; $display("FAIL inst_only_ready got inst=%b data=%b exp=1,0", inst_ready, data_ready);
    end
    checks++;
    if (s_vpn2 !== 19'h00200 || s_odd_page !== 1'b1) begin
      failures++; $display("FAIL inst_only_search got vpn2=%h odd=%b exp=00200,1", s_vpn2, s_odd_page);
    end
    tick();
    inst_req = 1'b0;
    set_tlb(1'b0, 20'h0, 1'b0, 1'b0);
    checks++;
    if (inst_resp_valid !== 1'b1 || inst_paddr !== 32'h1234_5ABC) begin
      failures++; $display("FAIL inst_only_resp got valid=%b paddr=%h exp=1,12345abc", inst_resp_valid, inst_paddr);
    end
    checks++;
    if (inst_refill !== 1'b0 || inst_invalid !== 1'b0) begin
      failures++; $display("FAIL inst_only_flags got refill=%b invalid=%b exp=0,0", inst_refill, inst_invalid);
    end
    inst_resp_ready = 1'b1;
    tick();
    checks++;
    if (inst_resp_valid !== 1'b0) begin
      failures++; $display("FAIL inst_only_drain got valid=%b exp=0", inst_resp_valid);
    end
  endtask

  task automatic test_bypass();
    idle();
    data_req = 1'b1; data_vaddr = 32'hA000_0010;
    set_tlb(1'b0, 20'hFFFFF, 1'b0, 1'b0);
    #1;
    checks++;
    if (s_vpn2 !== 19'h50000 || s_odd_page !== 1'b0) begin
      failures++; $display("FAIL bypass_search got vpn2=%h odd=%b exp=50000,0", s_vpn2, s_odd_page);
    end
    tick();
    data_vaddr = 32'h8000_0020;   // back-to-back kseg0 grant while draining
    checks++;
    if (data_resp_valid !== 1'b1 || data_paddr !== 32'h0000_0010 || data_refill !== 1'b0) begin
      failures++; $display("FAIL bypass_kseg1 got valid=%b paddr=%h refill=%b exp=1,00000010,0",
                           data_resp_valid, data_paddr, data_refill);
    end
    #1;
    checks++;
    if (data_ready !== 1'b1) begin failures++; $display("FAIL bypass_b2b_ready got=%b exp=1", data_ready); end
    tick();
    data_req = 1'b0;
    checks++;
    if (data_resp_valid !== 1'b1 || data_paddr !== 32'h0000_0020 || data_refill !== 1'b0) begin
      failures++; $display("FAIL bypass_kseg0 got valid=%b paddr=%h refill=%b exp=1,00000020,0",
                           data_resp_valid, data_paddr, data_refill);
    end
    tick();
  endtask

  task automatic test_exceptions();
    idle();
    do_data(32'h0000_3000, 1'b0, 1'b0, 20'h00ABC, 1'b0, 1'b0);
    checks++;
    if ({data_refill, data_invalid, data_modified} !== 3'b100 || data_paddr !== 32'h00AB_C000) begin
      failures++; $display("FAIL exc_refill got r/i/m=%b paddr=%h exp=100,00abc000",
                           {data_refill, data_invalid, data_modified}, data_paddr);
    end
    do_data(32'h0000_4000, 1'b0, 1'b1, 20'h00111, 1'b0, 1'b0);
    checks++;
    if ({data_refill, data_invalid, data_modified} !== 3'b010 || data_paddr !== 32'h0011_1000) begin
      failures++; $display("FAIL exc_invalid got r/i/m=%b paddr=%h exp=010,00111000",
                           {data_refill, data_invalid, data_modified}, data_paddr);
    end
    do_data(32'h0000_5004, 1'b1, 1'b1, 20'h00222, 1'b1, 1'b0);
    checks++;
    if ({data_refill, data_invalid, data_modified} !== 3'b001 || data_paddr !== 32'h0022_2004) begin
      failures++; $display("FAIL exc_modified got r/i/m=%b paddr=%h exp=001,00222004",
                           {data_refill, data_invalid, data_modified}, data_paddr);
    end
    do_data(32'h0000_5004, 1'b0, 1'b1, 20'h00222, 1'b1, 1'b0);
    checks++;
    if ({data_refill, data_invalid, data_modified} !== 3'b000) begin
      failures++; $display("FAIL exc_load_clean got r/i/m=%b exp=000", {data_refill, data_invalid, data_modified});
    end
    do_data(32'h0000_6000, 1'b1, 1'b0, 20'h00333, 1'b0, 1'b0);
    checks++;
    if ({data_refill, data_invalid, data_modified} !== 3'b100) begin
      failures++; $display("FAIL exc_store_miss got r/i/m=%b exp=100", {data_refill, data_invalid, data_modified});
    end
    // inst side: miss then invalid, back-to-back
    inst_req = 1'b1; inst_vaddr = 32'h0040_6000;
    set_tlb(1'b0, 20'h0, 1'b0, 1'b0);
    tick();
    set_tlb(1'b1, 20'h00444, 1'b0, 1'b0);
    checks++;
    if (inst_resp_valid !== 1'b1 || inst_refill !== 1'b1 || inst_invalid !== 1'b0) begin
      failures++; $display("FAIL exc_inst_refill got valid=%b refill=%b invalid=%b exp=1,1,0",
                           inst_resp_valid, inst_refill, inst_invalid);
    end
    tick();
    inst_req = 1'b0;
    checks++;
    if (inst_refill !== 1'b0 || inst_invalid !== 1'b1 || inst_paddr !== 32'h0044_4000) begin
      failures++; $display("FAIL exc_inst_invalid got refill=%b invalid=%b paddr=%h exp=0,1,00444000",
                           inst_refill, inst_invalid, inst_paddr);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [7:0] exp_inst;
    exp_inst = 8'b1000_1000;   // D,D,D,I,D,D,D,I from cycle 0
    idle();
    inst_req = 1'b1; inst_vaddr = 32'h0040_0000;
    data_req = 1'b1; data_vaddr = 32'h8000_0000;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (inst_ready !== exp_inst[i] || data_ready !== !exp_inst[i]) begin
        failures++; $display("FAIL starve_cycle%0d got inst=%b data=%b exp=%b,%b",
                             i, inst_ready, data_ready, exp_inst[i], !exp_inst[i]);
      end
      tick();
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_back_pressure();
    idle();
    inst_resp_ready = 1'b0;
    inst_req = 1'b1; inst_vaddr = 32'h0040_2004;
    set_tlb(1'b1, 20'h11111, 1'b1, 1'b0);
    tick();
    inst_vaddr = 32'h0040_3008;
    set_tlb(1'b1, 20'h22222, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (inst_ready !== 1'b0 || inst_resp_valid !== 1'b1 || inst_paddr !== 32'h1111_1004) begin
        failures++; $display("FAIL bp_hold%0d got ready=%b valid=%b paddr=%h exp=0,1,11111004",
                             i, inst_ready, inst_resp_valid, inst_paddr);
      end
      tick();
    end
    inst_resp_ready = 1'b1;
    #1;
    checks++;
    if (inst_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", inst_ready); end
    tick();
    inst_req = 1'b0;
    checks++;
    if (inst_resp_valid !== 1'b1 || inst_paddr !== 32'h2222_2008) begin
      failures++; $display("FAIL bp_regrant got valid=%b paddr=%h exp=1,22222008", inst_resp_valid, inst_paddr);
    end
    tick();
  endtask

  task automatic test_flush();
    idle();
    inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
    inst_req = 1'b1; inst_vaddr = 32'h0040_5000;
    set_tlb(1'b1, 20'h33333, 1'b1, 1'b0);
    tick();
    inst_req = 1'b0;
    data_req = 1'b1; data_vaddr = 32'h8000_0100;
    tick();
    data_req = 1'b0;
    // both slots full; flush with inst still requesting
    flush = 1'b1; inst_req = 1'b1; inst_vaddr = 32'h0040_7000;
    #1;
    checks++;
    if (inst_ready !== 1'b0) begin failures++; $display("FAIL flush_full_no_grant got=%b exp=0", inst_ready); end
    tick();
    flush = 1'b0; inst_req = 1'b0;
    checks++;
    if (inst_resp_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got valid=%b exp=0", inst_resp_valid); end
    checks++;
    if (data_resp_valid !== 1'b1 || data_paddr !== 32'h0000_0100) begin
      failures++; $display("FAIL flush_data_intact got valid=%b paddr=%h exp=1,00000100", data_resp_valid, data_paddr);
    end
    // empty inst slot, ready consumer: would grant without flush
    flush = 1'b1; inst_req = 1'b1; inst_resp_ready = 1'b1;
    #1;
    checks++;
    if (inst_ready !== 1'b0) begin failures++; $display("FAIL flush_empty_no_grant got=%b exp=0", inst_ready); end
    tick();
    flush = 1'b0; inst_req = 1'b0;
    checks++;
    if (inst_resp_valid !== 1'b0 || data_resp_valid !== 1'b1) begin
      failures++; $display("FAIL flush_after got inst_valid=%b data_valid=%b exp=0,1", inst_resp_valid, data_resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    // data slot still full from the flush scenario; start an inst grant
    inst_req = 1'b1; inst_vaddr = 32'h0040_8000; inst_resp_ready = 1'b1;
    data_resp_ready = 1'b0;
    set_tlb(1'b1, 20'h55555, 1'b1, 1'b1);
    tick();
    checks++;
    if (inst_resp_valid !== 1'b1 || data_resp_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_setup got inst=%b data=%b exp=1,1", inst_resp_valid, data_resp_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (inst_resp_valid !== 1'b0 || data_resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async got inst=%b data=%b exp=0,0", inst_resp_valid, data_resp_valid);
    end
    checks++;
    if (inst_paddr !== 32'h0 || data_paddr !== 32'h0) begin
      failures++; $display("FAIL rst_mid_paddr got inst=%h data=%h exp=0,0", inst_paddr, data_paddr);
    end
    idle();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checks++;
    if (inst_resp_valid !== 1'b0 || data_resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_after got inst=%b data=%b exp=0,0", inst_resp_valid, data_resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_inst_only();
    test_bypass();
    test_exceptions();
    test_starvation();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
